// File: rtl/mux2_share_arbiter.sv
// Round-robin owner sequencer for a shared 2:1 mux: grants one requester at a time,
// forwards its word over valid/ready and forces a hand-over after MAX_BURST transfers.
module mux2_share_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             out_ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             xfer0,
    output logic             xfer1
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             last_owner_q, last_owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             sel_q, sel_d;

    logic             transfer;
    logic             own_id;
    logic             own_req;
    logic             oth_req;
    state_e           oth_state;

    // State register; last_owner resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            sel_q        <= sel_d;
        end
    end

    // Next-state: owner-relative view so OWN0 and OWN1 share one rule set
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        own_id       = 1'b0;
        own_req      = 1'b0;
        oth_req      = 1'b0;
        oth_state    = IDLE;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                own_id    = (state_q == OWN1);
                own_req   = own_id ? req1 : req0;
                oth_req   = own_id ? req0 : req1;
                oth_state = own_id ? OWN0 : OWN1;
                if (!own_req) begin
                    state_d      = oth_req ? oth_state : IDLE;
                    burst_cnt_d  = '0;
                    last_owner_d = own_id;
                end else if (transfer && (burst_cnt_q == CNT_LAST) && oth_req) begin
                    state_d      = oth_state;
                    burst_cnt_d  = '0;
                    last_owner_d = own_id;
                end else if (transfer) begin
                    // Wraps while the other port is idle so ownership continues
                    burst_cnt_d = (burst_cnt_q == CNT_LAST) ? '0 : burst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase

        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
        // sel keeps its last value through IDLE
        sel_d  = (state_d == OWN1) ? 1'b1 : ((state_d == OWN0) ? 1'b0 : sel_q);
    end

    // Datapath-side outputs follow the registered grant and live requests
    always_comb begin
        out_valid = (gnt0_q & req0) | (gnt1_q & req1);
        out_data  = '0;
        if (gnt0_q && req0) begin
            out_data = data0;
        end else if (gnt1_q && req1) begin
            out_data = data1;
        end
        transfer = out_valid & out_ready;
        xfer0    = transfer & gnt0_q;
        xfer1    = transfer & gnt1_q;
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign sel  = sel_q;

endmodule
